// File: rtl/ens_lut_neuron_bank.sv
// Runtime-loadable bank of LogicNets truth-table neurons.
// CHANNELS independent lookup tables are evaluated in parallel through a
// two-stage valid/ready pipeline. ENSEMBLE=1 replaces the per-channel output
// with a per-bit strict majority vote. Table loads are drain-sequenced so no
// in-flight sample observes a partially written table.
module ens_lut_neuron_bank #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int CHANNELS = 4,
    parameter int ENSEMBLE = 0,
    localparam int OUT_W   = (ENSEMBLE != 0) ? OUT_BITS : CHANNELS * OUT_BITS,
    localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*IN_BITS-1:0]  in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             out_data,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [CHAN_W-1:0]            cfg_chan,
    input  logic [IN_BITS-1:0]           cfg_addr,
    input  logic [OUT_BITS-1:0]          cfg_data,
    input  logic                         cfg_last
);

    localparam int DEPTH = 1 << IN_BITS;

    typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

    state_t              state, state_nx;
    logic [OUT_BITS-1:0] tbl    [CHANNELS][DEPTH];
    logic [OUT_BITS-1:0] rd     [CHANNELS];
    logic [OUT_BITS-1:0] s1_lut [CHANNELS];
    logic                s1_valid;
    logic                s2_valid;
    logic [OUT_W-1:0]    s2_data;
    logic [OUT_W-1:0]    s2_word;
    logic                s2_load;
    logic                in_fire;
    logic                cfg_fire;

    assign s2_load   = !s2_valid || out_ready;
    // rst_n gates in_ready so nothing is advertised while reset is held
    assign in_ready  = rst_n && (state == RUN) && (!s1_valid || s2_load);
    assign in_fire   = in_valid && in_ready;
    assign cfg_ready = (state == LOAD);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign out_valid = s2_valid;
    assign out_data  = s2_data;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nx;
    end

    // Next-state logic: DRAIN leaves at the edge that empties the pipeline
    // (S1 empty and S2 empty or being consumed), so LOAD never overlaps a sample
    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (cfg_valid) state_nx = DRAIN;
            DRAIN:   if (!s1_valid && (!s2_valid || out_ready)) state_nx = LOAD;
            LOAD:    if (cfg_valid && cfg_last) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // Table storage; writes to a channel index >= CHANNELS match no table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < CHANNELS; c++)
                for (int unsigned a = 0; a < DEPTH; a++)
                    tbl[c][a] <= '0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++)
                if (cfg_fire && ({1'b0, cfg_chan} == (CHAN_W+1)'(c)))
                    tbl[c][cfg_addr] <= cfg_data;
        end
    end

    // Combinational lookup of every channel's current address
    always_comb begin
        for (int unsigned c = 0; c < CHANNELS; c++)
            rd[c] = tbl[c][in_data[c*IN_BITS +: IN_BITS]];
    end

    // Stage 1: capture lookups on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            for (int unsigned c = 0; c < CHANNELS; c++) s1_lut[c] <= '0;
        end else if (!s1_valid || s2_load) begin
            s1_valid <= in_fire;
            if (in_fire)
                for (int unsigned c = 0; c < CHANNELS; c++) s1_lut[c] <= rd[c];
        end
    end

    generate
        if (ENSEMBLE != 0) begin : g_vote
            localparam int CNT_W = $clog2(CHANNELS + 1);
            logic [CNT_W-1:0] cnt;

            // Per-bit strict majority: ties resolve to 0
            always_comb begin
                s2_word = '0;
                cnt     = '0;
                for (int unsigned b = 0; b < OUT_BITS; b++) begin
                    cnt = '0;
                    for (int unsigned c = 0; c < CHANNELS; c++)
                        cnt = cnt + CNT_W'(s1_lut[c][b]);
                    s2_word[b] = (cnt > CNT_W'(CHANNELS / 2));
                end
            end
        end else begin : g_cat
            // Per-channel concatenation of lookups
            always_comb begin
                s2_word = '0;
                for (int unsigned c = 0; c < CHANNELS; c++)
                    s2_word[c*OUT_BITS +: OUT_BITS] = s1_lut[c];
            end
        end
    endgenerate

    // Stage 2: output register, held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) s2_data <= s2_word;
        end
    end

endmodule

// File: tb/tb_ens_lut_neuron_bank.sv
// Directed bench for ens_lut_neuron_bank: per-channel bank, 4- and 3-channel
// ensemble banks, drain sequencing, backpressure scoreboard and reset cases.
module tb_ens_lut_neuron_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  in_v;
    logic [2:0]  cfg_v;
    logic [31:0] in_d;
    logic [23:0] in_d3;
    logic        out_ready;
    logic [1:0]  cfg_chan;
    logic [7:0]  cfg_addr;
    logic        cfg_data;
    logic        cfg_last;

    wire  [2:0]  in_rdy;
    wire  [2:0]  out_vld;
    wire  [2:0]  cfg_rdy;
    wire  [3:0]  out_d0;
    wire         out_d1;
    wire         out_d2;

    int          n_assert = 0;
    int          n_fail   = 0;
    bit          mtab [4][256];

    always #5 clk = ~clk;

    ens_lut_neuron_bank #(.IN_BITS(8), .OUT_BITS(1), .CHANNELS(4), .ENSEMBLE(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_v[0]), .in_ready(in_rdy[0]), .in_data(in_d),
        .out_valid(out_vld[0]), .out_ready(out_ready), .out_data(out_d0),
        .cfg_valid(cfg_v[0]), .cfg_ready(cfg_rdy[0]), .cfg_chan(cfg_chan),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_last(cfg_last));

    ens_lut_neuron_bank #(.IN_BITS(8), .OUT_BITS(1), .CHANNELS(4), .ENSEMBLE(1)) u_ens4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_v[1]), .in_ready(in_rdy[1]), .in_data(in_d),
        .out_valid(out_vld[1]), .out_ready(out_ready), .out_data(out_d1),
        .cfg_valid(cfg_v[1]), .cfg_ready(cfg_rdy[1]), .cfg_chan(cfg_chan),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_last(cfg_last));

    ens_lut_neuron_bank #(.IN_BITS(8), .OUT_BITS(1), .CHANNELS(3), .ENSEMBLE(1)) u_ens3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_v[2]), .in_ready(in_rdy[2]), .in_data(in_d3),
        .out_valid(out_vld[2]), .out_ready(out_ready), .out_data(out_d2),
        .cfg_valid(cfg_v[2]), .cfg_ready(cfg_rdy[2]), .cfg_chan(cfg_chan),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_last(cfg_last));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dout(input int d);
        if (d == 0)      return {28'd0, out_d0};
        else if (d == 1) return {31'd0, out_d1};
        else             return {31'd0, out_d2};
    endfunction

    function automatic logic [3:0] model(input logic [31:0] d);
        logic [3:0] r;
        for (int c = 0; c < 4; c++) r[c] = mtab[c][d[c*8 +: 8]];
        return r;
    endfunction

    // Offer one sample; returns at the negedge after the accepting edge
    task automatic push(input int d, input logic [31:0] data);
        int n = 0;
        in_d  = data;
        in_d3 = data[23:0];
        in_v[d] = 1'b1;
        #1;
        while (!in_rdy[d] && n < 100) begin @(negedge clk); #1; n++; end
        chk("push_timeout", 32'(n < 100), 32'd1);
        @(negedge clk);
        in_v[d] = 1'b0;
    endtask

    // Wait for a result and consume it
    task automatic get(input int d, input logic [31:0] exp, input string tag);
        int n = 0;
        out_ready = 1'b1;
        #1;
        while (!out_vld[d] && n < 100) begin @(negedge clk); #1; n++; end
        chk("get_timeout", 32'(n < 100), 32'd1);
        chk(tag, dout(d), exp);
        @(negedge clk);
    endtask

    task automatic cfg_wr(input int d, input int ch, input int addr, input bit data, input bit last);
        int n = 0;
        cfg_chan = 2'(ch);
        cfg_addr = 8'(addr);
        cfg_data = data;
        cfg_last = last;
        cfg_v[d] = 1'b1;
        #1;
        while (!cfg_rdy[d] && n < 100) begin @(negedge clk); #1; n++; end
        chk("cfg_timeout", 32'(n < 100), 32'd1);
        @(negedge clk);
        cfg_v[d] = 1'b0;
        if (d == 0 && ch < 4) mtab[ch][addr] = data;
    endtask

    // Continuous stream into the per-channel bank with random out_ready
    task automatic stream(input int n, input int pct);
        logic [3:0] exp_q[$];
        logic [3:0] hold = '0;
        bit stall = 0, fire_in, fire_out;
        int sent = 0, got = 0, cyc = 0;
        in_d = $urandom;
        in_v[0] = 1'b1;
        while (got < n && cyc < 20000) begin
            out_ready = ($urandom_range(0, 99) < pct);
            #1;
            if (stall) begin
                chk("stall_valid", 32'(out_vld[0]), 32'd1);
                chk("stall_data", 32'(out_d0), 32'(hold));
            end
            if (pct >= 100 && sent < n) chk("full_rate_in_ready", 32'(in_rdy[0]), 32'd1);
            fire_in  = in_v[0] && in_rdy[0];
            fire_out = out_vld[0] && out_ready;
            if (fire_out) begin
                if (exp_q.size() == 0) chk("bp_extra_output", 32'd1, 32'd0);
                else chk("bp_data", 32'(out_d0), 32'(exp_q.pop_front()));
                got++;
            end
            if (fire_in) begin exp_q.push_back(model(in_d)); sent++; end
            stall = out_vld[0] && !out_ready;
            hold  = out_d0;
            @(negedge clk);
            cyc++;
            if (fire_in) begin
                if (sent < n) in_d = $urandom;
                else in_v[0] = 1'b0;
            end
        end
        chk("bp_count", 32'(got), 32'(n));
        if (pct >= 100) chk("full_rate_cycles", 32'(cyc), 32'(n + 2));
        out_ready = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_v = '0; cfg_v = '0; in_d = '0; in_d3 = '0; out_ready = 1'b1;
        cfg_chan = '0; cfg_addr = '0; cfg_data = 1'b0; cfg_last = 1'b0;
        for (int c = 0; c < 4; c++) for (int a = 0; a < 256; a++) mtab[c][a] = 0;

        // Reset values
        @(negedge clk); @(negedge clk);
        chk("rst_in_ready", 32'(in_rdy[0]), 32'd0);
        chk("rst_out_valid", 32'(out_vld[0]), 32'd0);
        chk("rst_out_data", 32'(out_d0), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_rdy[0]), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_rdy[0]), 32'd1);

        // First sample, latency of two edges
        @(negedge clk);
        in_d = '0; in_v[0] = 1'b1;
        @(negedge clk);
        in_v[0] = 1'b0;
        chk("lat_s1_only", 32'(out_vld[0]), 32'd0);
        @(negedge clk);
        chk("lat_out_valid", 32'(out_vld[0]), 32'd1);
        chk("lat_out_data", 32'(out_d0), 32'h0);
        @(negedge clk);
        chk("lat_consumed", 32'(out_vld[0]), 32'd0);

        // Load and read back
        cfg_chan = 2'd0; cfg_addr = 8'h80; cfg_data = 1'b1; cfg_last = 1'b0; cfg_v[0] = 1'b1;
        #1;
        chk("cfg_ready_in_run", 32'(cfg_rdy[0]), 32'd0);
        cfg_wr(0, 0, 8'h80, 1, 0);
        cfg_wr(0, 1, 8'hA0, 1, 0);
        cfg_wr(0, 2, 8'h0B, 1, 1);
        #1;
        chk("load_back_in_ready", 32'(in_rdy[0]), 32'd1);
        chk("load_back_cfg_ready", 32'(cfg_rdy[0]), 32'd0);
        push(0, 32'h0B0BA080); get(0, 32'h7, "rb_0b0ba080");
        push(0, 32'h000BA080); get(0, 32'h7, "rb_000ba080");
        push(0, 32'h00000000); get(0, 32'h0, "rb_zero");

        // Drain ordering: A in S1, then B accepted on the RUN->DRAIN edge
        out_ready = 1'b0;
        in_d = 32'h0B0BA080; in_v[0] = 1'b1;
        @(negedge clk);
        in_d = 32'h00000080;
        cfg_chan = 2'd3; cfg_addr = 8'h0B; cfg_data = 1'b1; cfg_last = 1'b1; cfg_v[0] = 1'b1;
        #1;
        chk("drain_edge_in_ready", 32'(in_rdy[0]), 32'd1);
        @(negedge clk);
        in_v[0] = 1'b0;
        #1;
        chk("drain_in_ready", 32'(in_rdy[0]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("drain_cfg_ready_stalled", 32'(cfg_rdy[0]), 32'd0);
            chk("drain_hold_data", 32'(out_d0), 32'h7);
        end
        out_ready = 1'b1;
        #1;
        chk("drain_out_a", 32'(out_d0), 32'h7);
        chk("drain_cfg_ready_a", 32'(cfg_rdy[0]), 32'd0);
        @(negedge clk); #1;
        chk("drain_out_b_valid", 32'(out_vld[0]), 32'd1);
        chk("drain_out_b", 32'(out_d0), 32'h1);
        chk("drain_cfg_ready_b", 32'(cfg_rdy[0]), 32'd0);
        @(negedge clk); #1;
        chk("drain_load_reached", 32'(cfg_rdy[0]), 32'd1);
        chk("drain_empty", 32'(out_vld[0]), 32'd0);
        @(negedge clk);
        cfg_v[0] = 1'b0;
        mtab[3][8'h0B] = 1;
        #1;
        chk("drain_back_run", 32'(in_rdy[0]), 32'd1);
        push(0, 32'h0B0BA080); get(0, 32'hF, "drain_new_table");

        // Ensemble, 4 channels
        cfg_wr(1, 0, 8'h05, 1, 0);
        cfg_wr(1, 1, 8'h05, 1, 0);
        cfg_wr(1, 2, 8'h05, 1, 1);
        push(1, 32'h05050505); get(1, 32'd1, "ens4_three_of_four");
        cfg_wr(1, 2, 8'h05, 0, 1);
        push(1, 32'h05050505); get(1, 32'd0, "ens4_tie");

        // Ensemble, 3 channels, plus out-of-range channel write
        cfg_wr(2, 0, 8'h05, 1, 0);
        cfg_wr(2, 1, 8'h05, 1, 1);
        push(2, 32'h050505); get(2, 32'd1, "ens3_two_of_three");
        cfg_wr(2, 3, 8'h05, 1, 1);
        #1;
        chk("ens3_bad_chan_last", 32'(in_rdy[2]), 32'd1);
        cfg_wr(2, 1, 8'h05, 0, 1);
        push(2, 32'h050505); get(2, 32'd0, "ens3_one_of_three");

        // Random tables, then backpressure and full-rate streams
        for (int i = 0; i < 60; i++)
            cfg_wr(0, $urandom_range(0, 3), $urandom_range(0, 255), 1'($urandom), (i == 59));
        stream(1000, 30);
        stream(20, 100);

        // Reset mid-stream
        out_ready = 1'b0;
        push(0, 32'h0B0BA080);
        push(0, 32'h0B0BA080);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ms_out_valid", 32'(out_vld[0]), 32'd0);
        chk("rst_ms_out_data", 32'(out_d0), 32'd0);
        chk("rst_ms_in_ready", 32'(in_rdy[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) for (int a = 0; a < 256; a++) mtab[c][a] = 0;
        out_ready = 1'b1;
        #1;
        chk("rst_ms_run", 32'(in_rdy[0]), 32'd1);
        @(negedge clk); #1;
        chk("rst_ms_no_stale", 32'(out_vld[0]), 32'd0);
        push(0, 32'h0B0BA080); get(0, 32'h0, "rst_ms_table_clear");

        // Reset mid-LOAD
        cfg_wr(0, 0, 8'h80, 1, 0);
        cfg_wr(0, 1, 8'h11, 1, 0);
        #1;
        chk("mid_load_cfg_ready", 32'(cfg_rdy[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ml_cfg_ready", 32'(cfg_rdy[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ml_run", 32'(in_rdy[0]), 32'd1);
        chk("rst_ml_cfg_ready_after", 32'(cfg_rdy[0]), 32'd0);
        push(0, 32'h00001180); get(0, 32'h0, "rst_ml_table_clear");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
